// File: rtl/top_mpi_pkg.sv
// Shared types and constants for the MPI work node.
package top_mpi_pkg;

    // Width of the rank identity and of the step counter.
    localparam int unsigned RANK_W = 32;

    // Supported range for the work latency parameter.
    localparam int unsigned WORK_LATENCY_MIN = 1;
    localparam int unsigned WORK_LATENCY_MAX = 8;

    // Node lifecycle: waiting for the first step, stepping, permanently finalized.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Keeps an out-of-range latency from building a zero-width or huge pipeline.
    function automatic int unsigned clamp_latency(input int unsigned lat);
        if (lat < WORK_LATENCY_MIN) return WORK_LATENCY_MIN;
        if (lat > WORK_LATENCY_MAX) return WORK_LATENCY_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/top_mpi_valid_pipe.sv
// Valid-bit shift register: a bit entering at the input appears at the
// output DEPTH-1 edges later. Synchronous clear drops everything in flight.
module top_mpi_valid_pipe
    import top_mpi_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic clear,
    input  logic valid_in,
    output logic valid_out
);

    logic [DEPTH-1:0] stages;

    // Shift one stage per cycle; clear wipes every stage so no stale step survives.
    // NOTE: every pipeline stage is reset, not just the head, because a stale bit
    // deeper in the chain would otherwise emerge as a phantom pulse after reset.
    always_ff @(posedge clk) begin
        if (clear) begin
            stages <= '0;
        end else begin
            stages <= (stages << 1) | DEPTH'(valid_in);
        end
    end

    assign valid_out = stages[DEPTH-1];

endmodule

// File: rtl/top_mpi.sv
// MPI work node: accepts work strobes until finalized or until the step
// limit is reached, and reports each step WORK_LATENCY cycles later with
// a one-cycle valid pulse tagged with this node's rank.
module top_mpi
    import top_mpi_pkg::*;
#(
    parameter logic [RANK_W-1:0] RANK         = '0,
    parameter int unsigned       WORK_LATENCY = 2,
    parameter logic [31:0]       MAX_STEPS    = 32'hFFFF_FFFF
) (
    input  logic              clk_i,
    input  logic              rstn_i,      // active-high synchronous reset
    input  logic              finalize_i,
    input  logic              mpi_work,
    output logic [RANK_W-1:0] rank_o,
    output logic              valid_o
);

    // The output register supplies the last cycle of latency, so the
    // shift pipeline itself is one stage shorter in effect.
    localparam int unsigned PIPE_DEPTH = clamp_latency(WORK_LATENCY);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] step_cnt;
    logic        accept;
    logic        limit_hit;
    logic        pipe_out;

    // Next-state and step acceptance; finalize takes priority over a strobe.
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        limit_hit = (step_cnt == MAX_STEPS - 32'd1);
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (finalize_i) begin
                    state_d = ST_DONE;
                end else if (mpi_work) begin
                    accept  = 1'b1;
                    state_d = limit_hit ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and step counter; reset overrides any unknown input.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            state_q  <= ST_IDLE;
            step_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                step_cnt <= step_cnt + 32'd1;
            end
        end
    end

    top_mpi_valid_pipe #(
        .DEPTH(PIPE_DEPTH)
    ) u_valid_pipe (
        .clk      (clk_i),
        .clear    (rstn_i),
        .valid_in (accept),
        .valid_out(pipe_out)
    );

    // Registered outputs: rank is shown only alongside a valid pulse.
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            valid_o <= 1'b0;
            rank_o  <= '0;
        end else begin
            valid_o <= pipe_out;
            rank_o  <= pipe_out ? RANK : '0;
        end
    end

endmodule

// File: tb/tb_top_mpi.sv
// Self-checking bench for top_mpi: three instances with different latency,
// limit and rank share one stimulus stream and are compared every cycle
// against a due-time queue model.
module tb_top_mpi;
    import top_mpi_pkg::*;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    logic fin;
    logic work;

    logic        dut_valid [NI];
    logic [31:0] dut_rank  [NI];
    logic [31:0] dut_cnt   [NI];
    state_t      dut_state [NI];
    logic        exp_valid [NI];
    logic [31:0] exp_rank  [NI];
    logic [31:0] exp_cnt   [NI];

    int  n_vec  = 0;
    int  n_err  = 0;
    bit  cmp_en = 1'b0;
    int  pulses [NI];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 1 : 8;
        localparam logic [31:0] M = (g == 0) ? 32'hFFFF_FFFF : (g == 1) ? 32'd4 : 32'd6;
        localparam logic [31:0] R = (g == 0) ? 32'd3 : (g == 1) ? 32'd7 : 32'hA5A5_0001;

        logic        v;
        logic [31:0] r;

        top_mpi #(
            .RANK        (R),
            .WORK_LATENCY(L),
            .MAX_STEPS   (M)
        ) dut (
            .clk_i     (clk),
            .rstn_i    (rst),
            .finalize_i(fin),
            .mpi_work  (work),
            .rank_o    (r),
            .valid_o   (v)
        );

        assign dut_valid[g] = v;
        assign dut_rank[g]  = r;
        assign dut_cnt[g]   = dut.step_cnt;
        assign dut_state[g] = dut.state_q;

        // Model: each accepted step schedules a pulse at (edge index + L);
        // reset forgets all schedules; finalize or reaching M stops accepting.
        int unsigned due_q[$];
        bit          done;
        int unsigned cnt;
        int unsigned cyc;
        bit          ev;

        initial begin
            done = 1'b0;
            cnt  = 0;
            cyc  = 0;
            ev   = 1'b0;
            forever begin
                @(posedge clk);
                cyc++;
                if (rst) begin
                    due_q.delete();
                    done = 1'b0;
                    cnt  = 0;
                    ev   = 1'b0;
                end else begin
                    ev = (due_q.size() > 0) && (due_q[0] == cyc);
                    if (ev) void'(due_q.pop_front());
                    if (fin) begin
                        done = 1'b1;
                    end else if (work && !done) begin
                        cnt++;
                        due_q.push_back(cyc + L);
                        if (cnt == M) done = 1'b1;
                    end
                end
            end
        end

        assign exp_valid[g] = ev;
        assign exp_rank[g]  = ev ? R : 32'd0;
        assign exp_cnt[g]   = cnt;
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int g = 0; g < NI; g++) begin
                check($sformatf("valid[%0d]", g), 64'(dut_valid[g]), 64'(exp_valid[g]));
                check($sformatf("rank[%0d]", g), 64'(dut_rank[g]), 64'(exp_rank[g]));
                check($sformatf("step_cnt[%0d]", g), 64'(dut_cnt[g]), 64'(exp_cnt[g]));
            end
        end
    end

    // Apply one cycle of inputs; returns at the following falling edge.
    task automatic drive(input bit w, input bit f, input bit r);
        work = w;
        fin  = f;
        rst  = r;
        @(negedge clk);
        for (int g = 0; g < NI; g++) if (dut_valid[g]) pulses[g]++;
    endtask

    task automatic clear_pulses();
        for (int g = 0; g < NI; g++) pulses[g] = 0;
    endtask

    initial begin
        rst  = 1'b1;
        fin  = 1'b0;
        work = 1'b0;

        // Reset held 5 cycles with work pulsing: outputs stay quiet.
        for (int i = 0; i < 5; i++) begin
            drive(i[0], 1'b0, 1'b1);
            cmp_en = 1'b1;
            check("reset_valid", 64'(dut_valid[0]), 64'd0);
            check("reset_rank", 64'(dut_rank[0]), 64'd0);
        end
        drive(1'b0, 1'b0, 1'b0);
        check("cnt_after_reset", 64'(dut_cnt[0]), 64'd0);
        check("state_after_reset", 64'(dut_state[0]), 64'(ST_IDLE));

        // Single strobe: pulse exactly L cycles after the accepting edge.
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            check($sformatf("lat2_k%0d", k), 64'(dut_valid[0]), 64'(k == 2));
            check($sformatf("lat1_k%0d", k), 64'(dut_valid[1]), 64'(k == 1));
            check($sformatf("lat8_k%0d", k), 64'(dut_valid[2]), 64'(k == 8));
            if (k == 2) check("rank3_on_pulse", 64'(dut_rank[0]), 64'd3);
            drive(1'b0, 1'b0, 1'b0);
        end

        // 20 back-to-back strobes.
        drive(1'b0, 1'b0, 1'b1);
        clear_pulses();
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b0);
        check("burst20_pulses_g0", 64'(pulses[0]), 64'd20);
        check("burst20_pulses_g1", 64'(pulses[1]), 64'd4);
        check("burst20_pulses_g2", 64'(pulses[2]), 64'd6);
        check("limit_done_g1", 64'(dut_state[1]), 64'(ST_DONE));

        // Step limit with work held for 10 cycles.
        drive(1'b0, 1'b0, 1'b1);
        clear_pulses();
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b0);
        check("hold10_pulses_g0", 64'(pulses[0]), 64'd10);
        check("hold10_pulses_g1", 64'(pulses[1]), 64'd4);
        check("hold10_cnt_g1", 64'(dut_cnt[1]), 64'd4);

        // Finalize together with a strobe after 5 steps.
        drive(1'b0, 1'b0, 1'b1);
        clear_pulses();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b0);
        check("final_pulses_g0", 64'(pulses[0]), 64'd5);
        check("final_pulses_g1", 64'(pulses[1]), 64'd4);
        check("final_pulses_g2", 64'(pulses[2]), 64'd5);
        check("final_state_g0", 64'(dut_state[0]), 64'(ST_DONE));

        // Reset one cycle after a strobe discards it.
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        clear_pulses();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("abort_state_g0", 64'(dut_state[0]), 64'(ST_IDLE));
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b0);
        check("abort_pulses_g0", 64'(pulses[0]), 64'd0);
        check("abort_pulses_g1", 64'(pulses[1]), 64'd0);
        check("abort_pulses_g2", 64'(pulses[2]), 64'd0);

        // Randomized traffic with occasional finalize and reset.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3, 0) != 0,
                  $urandom_range(149, 0) == 0,
                  $urandom_range(59, 0) == 0);
        end
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/top_mpi.md
TOP_MPI -- requirements
Module: top_mpi

Interface
REQ-001 Parameter RANK, default 0: 32-bit MPI rank identity of this node.
REQ-002 Parameter WORK_LATENCY, default 2, legal range 1..8: cycles from accepted work strobe to valid_o pulse.
REQ-003 Parameter MAX_STEPS, default 32'hFFFF_FFFF: accepted-work limit; the node self-finalizes when reached.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn_i  input  1  synchronous, active-high reset (1 = reset asserted).
REQ-006 finalize_i  input  1  level; request permanent shutdown of MPI activity.
REQ-007 mpi_work  input  1  work strobe, sampled at rising clk_i; high = one work step requested.
REQ-008 rank_o  output  32  equals RANK while valid_o=1, else 32'd0.
REQ-009 valid_o  output  1  one-cycle pulse per completed work step.

Function
REQ-010 FSM states: IDLE, RUN, DONE; encoding free, 2 bits.
REQ-011 IDLE: entered on reset; first sampled mpi_work=1 moves to RUN and is accepted as a step.
REQ-012 RUN: every cycle with mpi_work=1 and finalize_i=0 is one accepted step.
REQ-013 Accepted steps enter a WORK_LATENCY-deep valid shift pipeline; valid_o is high exactly WORK_LATENCY cycles after the accepting edge.
REQ-014 mpi_work held high N consecutive cycles yields N accepted steps and N consecutive valid_o pulses; no coalescing.
REQ-015 32-bit step counter increments per accepted step; at MAX_STEPS the FSM enters DONE on the same edge; it never wraps.
REQ-016 finalize_i=1 sampled in IDLE or RUN: go to DONE; mpi_work in that same cycle is not accepted.
REQ-017 On entering DONE, steps already in the pipeline still complete and pulse valid_o; no new steps are accepted.
REQ-018 DONE is absorbing until reset; finalize_i deassertion does not leave DONE.
REQ-019 rank_o is registered together with valid_o; no combinational path from inputs to outputs.
REQ-020 X on mpi_work or finalize_i while reset is asserted has no effect.

Reset
REQ-021 While rstn_i=1 at a rising edge: state=IDLE, pipeline cleared, step counter=0, valid_o=0, rank_o=0.
REQ-022 Reset mid-operation discards all in-flight steps; no valid_o pulse emerges after the reset edge.
REQ-023 mpi_work sampled in the same cycle as reset is ignored; the first step is accepted at the first edge with rstn_i=0.

Structure
REQ-024 Shared package top_mpi_pkg holds the state enum typedef, the RANK_W=32 width constant and the WORK_LATENCY bounds.
REQ-025 One sub-module, top_mpi_valid_pipe: parameterized valid shift register (depth WORK_LATENCY) with synchronous clear.
REQ-026 Top level holds the FSM, step counter and rank_o output register.

Verification
REQ-027 Reset held 5 cycles with mpi_work pulsing -> valid_o=0 and rank_o=0 throughout; step counter=0 after release.
REQ-028 RANK=3, 20 single-cycle mpi_work strobes one per cycle -> 20 valid_o pulses, each starting 2 cycles after its strobe, rank_o=3 on each, 0 otherwise.
REQ-029 finalize_i=1 together with mpi_work=1 after 5 steps -> that strobe dropped; in-flight steps still pulse; then valid_o stays 0 despite further strobes.
REQ-030 Reset asserted one cycle after a strobe (WORK_LATENCY=2) -> no valid_o pulse for that strobe; node returns to IDLE.
REQ-031 MAX_STEPS=4, mpi_work held high 10 cycles -> exactly 4 valid_o pulses, then DONE.
REQ-032 WORK_LATENCY=1 and 8 sweeps, each with a single strobe -> valid_o pulse exactly 1 and 8 cycles later respectively.
